// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver.
// Serial input -> 2-FF synchroniser -> sampling FSM -> held frame outputs.
// Output protocol: `flag` is a one-cycle strobe marking a completed frame;
// `data_byte`, `parity_err` and `frame_err` are loaded on that same cycle and
// hold until the next strobe. There is no back-pressure: a consumer that
// needs the data must capture it while `flag` is high or before the next frame.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_line,
  output logic                 flag,
  output logic [DATA_BITS-1:0] data_byte,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_END = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                 state_q;
  logic                   sync1_q, sync2_q;
  logic                   rx_s;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d, perr_d;
  logic                   ferr_q;
  logic                   armed_q;
  logic                   flag_q, perr_q, frame_err_q, busy_q;
  logic [DATA_BITS-1:0]   data_q;

  assign rx_s       = sync2_q;
  assign flag       = flag_q;
  assign data_byte  = data_q;
  assign parity_err = perr_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

  // Two-flop synchroniser; both stages reset to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= data_line;
      sync2_q <= sync1_q;
    end
  end

  // Next shift-register contents, running XOR and the parity verdict
  always_comb begin
    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
    par_d   = par_q ^ rx_s;
    case (PARITY)
      1:       perr_d = ~par_q;  // odd: XOR of data and parity must be 1
      2:       perr_d = par_q;   // even: XOR of data and parity must be 0
      default: perr_d = 1'b0;
    endcase
  end

  // Receive FSM with registered outputs. armed_q demands a high line level
  // before each new start, so a line stuck low after reset or after a
  // start entry cannot retrigger by itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ferr_q      <= 1'b0;
      armed_q     <= 1'b0;
      flag_q      <= 1'b0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      flag_q <= 1'b0;
      if (rx_s) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (!rx_s && armed_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            bit_q   <= '0;
            armed_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HALF_END) begin
            cnt_q <= '0;
            if (rx_s) begin
              // line back high at mid-start: treat as a glitch
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              par_q   <= 1'b0;
              ferr_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_END) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            par_q   <= par_d;
            if (bit_q == DATA_END) begin
              bit_q   <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_q == BIT_END) begin
            cnt_q   <= '0;
            par_q   <= par_d;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_END) begin
            cnt_q <= '0;
            if (!rx_s) begin
              ferr_q <= 1'b1;
            end
            if (bit_q == STOP_END) begin
              bit_q   <= '0;
              state_q <= S_DONE;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          data_q      <= shift_q;
          perr_q      <= perr_d;
          frame_err_q <= ferr_q;
          flag_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (default 8N1, 8E1, and 7O2 at
// 6 clocks per bit). Frames are described at bit level; a frame model turns
// each driven frame into the expected data, error flags and strobe cycle.
module tb_uart_rx_cfg;

  localparam int W = 43;  // {flag cycle[31:0], parity_err, frame_err, data[8:0]}

  localparam int CPB_OF [3] = '{8, 8, 6};
  localparam int ND_OF  [3] = '{8, 8, 7};
  localparam int PAR_OF [3] = '{0, 2, 1};
  localparam int NS_OF  [3] = '{1, 1, 2};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic line0 = 1'b1;
  logic line1 = 1'b1;
  logic line2 = 1'b1;

  logic       flag0, flag1, flag2;
  logic       busy0, busy1, busy2;
  logic       perr0, perr1, perr2;
  logic       ferr0, ferr1, ferr2;
  logic [7:0] data0, data1;
  logic [6:0] data2;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  int       flag_cnt  [3] = '{0, 0, 0};
  int       last_cyc  [3] = '{0, 0, 0};
  int       prev_cyc  [3] = '{0, 0, 0};
  logic [8:0] last_data [3];
  logic     last_perr [3];
  logic     last_ferr [3];
  logic     prev_busy [3] = '{1'b0, 1'b0, 1'b0};

  uart_rx_cfg dut0 (
    .clk(clk), .rst_n(rst_n), .data_line(line0), .flag(flag0),
    .data_byte(data0), .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_line(line1), .flag(flag1),
    .data_byte(data1), .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(6), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_line(line2), .flag(flag2),
    .data_byte(data2), .parity_err(perr2), .frame_err(ferr2), .busy(busy2)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int w);
    return 2 + CPB_OF[w] / 2
         + (ND_OF[w] + ((PAR_OF[w] != 0) ? 1 : 0) + NS_OF[w]) * CPB_OF[w] + 1;
  endfunction

  task automatic push(input int w, input logic [W-1:0] e);
    case (w)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // ---------------- scoreboard: one compare per strobe ----------------
  task automatic obs(input int w, input logic f, input logic b, input logic [8:0] d,
                     input logic pe, input logic fe);
    logic [W-1:0] e;
    bit have;
    e    = '0;
    have = 1'b0;
    if (f) begin
      case (w)
        0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
      endcase
      chk("busy_low_with_flag", 32'(b), 32'd0);
      chk("busy_high_before_flag", 32'(prev_busy[w]), 32'd1);
      if (!have) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_flag: dut%0d flag=1 data=%0h, expected no frame", w, d);
      end else begin
        chk("flag_cycle", 32'(cyc), e[42:11]);
        chk("data_byte", 32'(d), 32'(e[8:0]));
        chk("parity_err", 32'(pe), 32'(e[10]));
        chk("frame_err", 32'(fe), 32'(e[9]));
      end
      prev_cyc[w]  = last_cyc[w];
      last_cyc[w]  = cyc;
      last_data[w] = d;
      last_perr[w] = pe;
      last_ferr[w] = fe;
      flag_cnt[w]++;
    end
    prev_busy[w] = b;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      obs(0, flag0, busy0, {1'b0, data0}, perr0, ferr0);
      obs(1, flag1, busy1, {1'b0, data1}, perr1, ferr1);
      obs(2, flag2, busy2, {2'b00, data2}, perr2, ferr2);
    end
  end

  // ---------------- drivers ----------------
  task automatic set_line(input int w, input logic b);
    case (w)
      0:       line0 = b;
      1:       line1 = b;
      default: line2 = b;
    endcase
  endtask

  task automatic bit_out(input int w, input logic b);
    set_line(w, b);
    repeat (CPB_OF[w]) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int w, input int nbits);
    for (int i = 0; i < nbits; i++) bit_out(w, 1'b1);
  endtask

  // Drive one frame and record what the receiver must report for it
  task automatic frame_out(input int w, input logic [8:0] d_in, input logic pb,
                           input logic [1:0] st, output int t0);
    logic [8:0] d;
    logic pe, fe;
    d  = d_in & ((9'h1 << ND_OF[w]) - 9'h1);
    pe = 1'b0;
    if (PAR_OF[w] == 1) pe = ~(^d ^ pb);
    else if (PAR_OF[w] == 2) pe = ^d ^ pb;
    fe = (st[0] == 1'b0) || ((NS_OF[w] == 2) && (st[1] == 1'b0));
    t0 = cyc;
    push(w, {32'(t0 + 1 + lat_of(w)), pe, fe, d});
    bit_out(w, 1'b0);
    for (int i = 0; i < ND_OF[w]; i++) bit_out(w, d[i]);
    if (PAR_OF[w] != 0) bit_out(w, pb);
    for (int i = 0; i < NS_OF[w]; i++) bit_out(w, st[i]);
  endtask

  // ---------------- directed sequence ----------------
  int pat [12] = '{1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 1};

  initial begin
    int t;
    int c;
    bit saw_busy;
    logic [8:0] pd;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flag0", 32'(flag0), 32'd0);
    chk("rst_data0", 32'(data0), 32'd0);
    chk("rst_perr0", 32'(perr0), 32'd0);
    chk("rst_ferr0", 32'(ferr0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_flag1", 32'(flag1), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_flag2", 32'(flag2), 32'd0);
    chk("rst_data2", 32'(data2), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    idle(0, 2);

    // 0xA5 frame: strobe 79 cycles after the first sampling edge
    frame_out(0, 9'h0A5, 1'b0, 2'b11, t);
    idle(0, 3);
    chk("a5_latency", 32'(last_cyc[0] - t - 1), 32'd79);
    chk("a5_data", 32'(last_data[0]), 32'h0A5);
    chk("a5_perr", 32'(last_perr[0]), 32'd0);
    chk("a5_ferr", 32'(last_ferr[0]), 32'd0);
    chk("a5_count", 32'(flag_cnt[0]), 32'd1);

    // start glitch: line low for 3 cycles
    saw_busy = 1'b0;
    line0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy0) saw_busy = 1'b1;
      @(posedge clk);
      #1;
      if (k == 2) line0 = 1'b1;
    end
    @(negedge clk);
    chk("glitch_busy_seen", 32'(saw_busy), 32'd1);
    chk("glitch_busy_back_low", 32'(busy0), 32'd0);
    chk("glitch_data_held", 32'(data0), 32'h0A5);
    @(posedge clk);
    #1;
    idle(0, 2);
    chk("glitch_no_flag", 32'(flag_cnt[0]), 32'd1);

    // repeating 12-bit pattern: each period is one frame with a low stop bit
    c = flag_cnt[0];
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        if (i == 1) begin
          for (int j = 0; j < 8; j++) pd[j] = 1'(pat[2 + j]);
          pd[8] = 1'b0;
          push(0, {32'(cyc + 1 + lat_of(0)), 1'b0, (pat[10] == 0), pd});
        end
        bit_out(0, 1'(pat[i]));
      end
    end
    idle(0, 3);
    chk("pattern_count", 32'(flag_cnt[0] - c), 32'd3);
    chk("pattern_data", 32'(last_data[0]), 32'h05D);
    chk("pattern_ferr", 32'(last_ferr[0]), 32'd1);

    // back-to-back frames with no idle gap
    frame_out(0, 9'h012, 1'b0, 2'b11, t);
    frame_out(0, 9'h034, 1'b0, 2'b11, t);
    idle(0, 3);
    chk("b2b_spacing", 32'(last_cyc[0] - prev_cyc[0]), 32'd80);
    chk("b2b_last_data", 32'(last_data[0]), 32'h034);

    // reset during data bit 4 discards the frame
    c = flag_cnt[0];
    pd = 9'h0C3;
    bit_out(0, 1'b0);
    for (int i = 0; i < 4; i++) bit_out(0, pd[i]);
    line0 = pd[4];
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_flag", 32'(flag0), 32'd0);
    chk("midrst_data", 32'(data0), 32'd0);
    chk("midrst_perr", 32'(perr0), 32'd0);
    chk("midrst_ferr", 32'(ferr0), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    line0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0, 3);
    chk("midrst_no_flag", 32'(flag_cnt[0] - c), 32'd0);
    frame_out(0, 9'h05A, 1'b0, 2'b11, t);
    idle(0, 3);
    chk("after_rst_data", 32'(last_data[0]), 32'h05A);
    chk("after_rst_count", 32'(flag_cnt[0] - c), 32'd1);

    // even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right
    idle(1, 2);
    frame_out(1, 9'h003, 1'b1, 2'b11, t);
    idle(1, 3);
    chk("even_bad_perr", 32'(last_perr[1]), 32'd1);
    chk("even_bad_data", 32'(last_data[1]), 32'h003);
    frame_out(1, 9'h003, 1'b0, 2'b11, t);
    idle(1, 3);
    chk("even_good_perr", 32'(last_perr[1]), 32'd0);

    // odd parity, two stop bits: 0x55 has four ones
    idle(2, 2);
    frame_out(2, 9'h055, 1'b1, 2'b11, t);
    idle(2, 3);
    chk("odd_good_perr", 32'(last_perr[2]), 32'd0);
    chk("odd_good_ferr", 32'(last_ferr[2]), 32'd0);
    chk("odd_latency", 32'(last_cyc[2] - t - 1), 32'd66);
    frame_out(2, 9'h055, 1'b0, 2'b01, t);
    idle(2, 3);
    chk("odd_bad_perr", 32'(last_perr[2]), 32'd1);
    chk("odd_second_stop_ferr", 32'(last_ferr[2]), 32'd1);
    frame_out(2, 9'h02C, 1'b0, 2'b10, t);
    idle(2, 3);
    chk("odd_first_stop_ferr", 32'(last_ferr[2]), 32'd1);
    chk("odd_data", 32'(last_data[2]), 32'h02C);

    // every expected frame must have produced a strobe
    chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
    chk("exp_q2_drained", 32'(exp_q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that supersedes the fixed 8-bit receiver. It adds configurable bit timing, data width, parity and stop bits, a 2-FF input synchroniser, start-bit glitch rejection, and parity and framing error reporting. It sits between the board-level serial input pin and the byte-consuming logic, delivering one-cycle `flag` strobes with held data.

## Interface
- `CLKS_PER_BIT`, default 8: clock cycles per serial bit; legal range ≥4.
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `data_line`, in, 1: serial input, asynchronous to `clk`, idle high.
- `flag`, out, 1: one-cycle strobe; the frame is complete.
- `data_byte`, out, DATA_BITS: received data, LSB first on the line; held until the next `flag`.
- `parity_err`, out, 1: parity mismatch for the frame; valid with `flag`, held until the next `flag`.
- `frame_err`, out, 1: any stop bit sampled low; valid with `flag`, held until the next `flag`.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Reset values: `flag`=0, `data_byte`=0, `parity_err`=0, `frame_err`=0, `busy`=0. The FSM resets to IDLE, the counters to 0 and both synchroniser FFs to 1.
- `data_line` passes through a 2-FF synchroniser; the FSM sees only the synchronised signal `rx_s`.
- HALF = CLKS_PER_BIT/2, truncated.
- FSM states and transitions:
  - IDLE: on `rx_s`=0, go to START and clear the bit counter.
  - START: after HALF cycles, sample `rx_s`. If it is 1, the start was a glitch: return to IDLE with no flag and no error. If it is 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles and shift LSB-first into the shift register. After DATA_BITS samples, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: one sample. Compute the XOR of the data bits and the parity bit. For odd parity, error if the XOR is 0; for even parity, error if the XOR is 1.
  - STOP: STOP_BITS samples, CLKS_PER_BIT apart. Any sample of 0 sets frame_err.
  - DONE: lasts one cycle. Load `data_byte` and the error flags, pulse `flag`, then go to IDLE.
- A frame with a framing error still delivers its data and `flag`. Break frames (all zeros) report `frame_err`=1.
- After DONE, IDLE re-arms immediately, so back-to-back frames with no idle gap are received without loss.
- `rx_s` is ignored between sample points; there is no majority vote.

## Timing
- Latency from the falling edge of `data_line` (sampled by `clk`) to `flag` high is 2 + HALF + N·CLKS_PER_BIT + 1 cycles, where N = DATA_BITS + (PARITY≠0) + STOP_BITS. With the defaults this is 79 cycles.
- Each sample point falls HALF cycles into its bit, within ±1 cycle of bit centre.
- `flag` is high for exactly one cycle per accepted frame.
- `busy` rises one cycle after the START entry edge and falls on the cycle `flag` is high.
- Minimum frame spacing is 1 + HALF + N·CLKS_PER_BIT cycles, measured from start edge to start edge.
- `rst_n` low mid-frame: all outputs return to their reset values immediately, and the partial frame is discarded with no `flag`. After `rst_n` rises, the receiver waits for `rx_s`=1 then 0 before detecting a start.
- A `data_line` low pulse of HALF−1 cycles or fewer is rejected.

## Test plan
- Defaults, 8 clocks per bit, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop 1) → one `flag` at 79 cycles; `data_byte`=0xA5, both error flags 0.
- Defaults, repeating 12-bit pattern 1,0,1,0,1,1,1,0,1,0,0,1 at 8 clocks per bit:
  - First frame (start, data 1,0,1,1,1,0,1,0, stop 0) → `flag` with `data_byte`=0x5D and `frame_err`=1.
  - The next start is detected and every subsequent frame repeats 0x5D with `frame_err`=1.
- PARITY=2, data 0x03 with parity bit 1 → `flag`, `data_byte`=0x03, `parity_err`=1. The same frame with parity bit 0 → `parity_err`=0.
- Glitch: `data_line` low for 3 cycles, then high → no `flag`, `busy` returns to 0 within 7 cycles, outputs unchanged.
- Two back-to-back frames, 0x12 then 0x34, no idle gap → two `flag` pulses 80 cycles apart with `data_byte` 0x12 then 0x34.
- `rst_n` pulsed low during data bit 4 → no `flag` and outputs at reset values. A following 0x5A frame is received correctly.
